button_reader: RTL

//  Memory-mapped input peripheral; the read-side counterpart of the LED flash store at dmem addr 6.

---
 rtl/button_reader_if.sv | 19 +
 rtl/button_reader.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/button_reader_if.sv
// Processor dmem-side bus of the button reader: address, store/load strobes,
// address-hit flag and the status/event read word.
interface button_reader_if;
    logic [11:0] mem_addr;
    logic        mem_wren;
    logic        mem_rden;
    logic        hit;
    logic [31:0] read_data;

    modport master (
        output mem_addr, mem_wren, mem_rden,
        input  hit, read_data
    );

    modport slave (
        input  mem_addr, mem_wren, mem_rden,
        output hit, read_data
    );
endinterface

// File: rtl/button_reader.sv
// Button reader: synchronises (and optionally debounces) four buttons and queues
// press events in a 4-deep FIFO popped by lw. Debounce enabled by BUTTON_READER_DEBOUNCE_EN.
module button_reader #(
    parameter logic [11:0] ADDR            = 12'd7,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            red_button,
    input  logic            blue_button,
    input  logic            green_button,
    input  logic            yellow_button,
    button_reader_if.slave  bus
);

    logic [3:0] raw;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] stable, stable_nxt, rise;

    assign raw = {yellow_button, green_button, blue_button, red_button};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

`ifdef BUTTON_READER_DEBOUNCE_EN
    logic [3:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1))
                    stable_d[i] = sync2_q[i];
                else
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable_q <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            stable_q <= stable_d;
            for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign stable     = stable_q;
    assign stable_nxt = stable_d;
`else
    assign stable     = sync2_q;
    assign stable_nxt = sync1_q;
`endif

    // A press is flagged on the same edge that the stable level rises.
    assign rise = stable_nxt & ~stable;

    logic [3:0] pending_q, pending_d;
    logic [1:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ov_q, ov_d;

    logic       push_req, push_ok, pop, rd_hit, flush, full, found;
    logic [1:0] win_color;
    logic [3:0] win_oh;

    always_comb begin
        found     = 1'b0;
        win_color = 2'd0;
        win_oh    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (pending_q[i] && !found) begin
                found     = 1'b1;
                win_color = 2'(i);
                win_oh[i] = 1'b1;
            end
        end
    end

    assign push_req = |pending_q;
    assign rd_hit   = bus.mem_rden & bus.hit;
    assign flush    = bus.mem_wren & bus.hit;
    assign full     = (count_q == 3'd4);
    assign pop      = rd_hit & (count_q != 3'd0);
    assign push_ok  = push_req & (!full | pop);

    always_comb begin
        pending_d = pending_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ov_d      = ov_q;
        if (flush) begin
            pending_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ov_d      = 1'b0;
        end else begin
            // The winner's pending bit clears even when the event is dropped on overflow.
            pending_d = (pending_q & ~win_oh) | rise;
            if (push_ok) wr_ptr_d = wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_d = rd_ptr_q + 2'd1;
            count_d = count_q + 3'(push_ok) - 3'(pop);
            if (rd_hit)              ov_d = 1'b0;
            if (push_req && !push_ok) ov_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ov_q      <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ov_q      <= ov_d;
            if (push_ok && !flush) mem_q[wr_ptr_q] <= win_color;
        end
    end

    logic       valid;
    logic [1:0] head;

    assign valid         = (count_q != 3'd0);
    assign head          = valid ? mem_q[rd_ptr_q] : 2'd0;
    assign bus.hit       = (bus.mem_addr == ADDR);
    assign bus.read_data = {21'd0, count_q, stable, ov_q, head, valid};

endmodule
